// File: rtl/ic_tester_pkg.sv
// -----------------------------------------------------------------------------
// ic_tester_pkg
// Shared definitions for the dual 4-input gate IC emulator and the tester's
// reference model: gate and fault encodings, channel FSM states, the sampled
// configuration record and the pure gate/fault evaluation functions.
// -----------------------------------------------------------------------------
package ic_tester_pkg;

  localparam int NUM_CH = 2;   // two gates per package
  localparam int VEC_W  = 4;   // {D,C,B,A}
  localparam int COV_W  = 16;  // one bit per input pattern
  localparam int CNT_W  = 8;   // holds DELAY_CYCLES-1 for DELAY_CYCLES up to 255

  // gateSelect encodings; 6 and 7 fall back to AND.
  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NAND = 3'd2,
    GATE_NOR  = 3'd3,
    GATE_XOR  = 3'd4,
    GATE_XNOR = 3'd5
  } gate_sel_e;

  typedef enum logic [1:0] {
    FAULT_NONE = 2'd0,
    FAULT_SA0  = 2'd1,
    FAULT_SA1  = 2'd2,
    FAULT_PAT  = 2'd3
  } fault_mode_e;

  typedef enum logic [1:0] {
    CH_OFF     = 2'd0,
    CH_WAIT    = 2'd1,
    CH_SETTLED = 2'd2
  } ch_state_e;

  // Configuration sampled every edge; any change restarts both channels.
  typedef struct packed {
    logic [2:0] gate_sel;
    logic [1:0] fault_mode;
    logic [1:0] fault_target;
    logic [3:0] fault_pattern;
  } cfg_t;

  // Fault-free gate result for input vector v = {D,C,B,A}.
  function automatic logic gate_eval(input logic [2:0] sel, input logic [3:0] v);
    logic r;
    case (sel)
      GATE_OR:   r = |v;
      GATE_NAND: r = ~&v;
      GATE_NOR:  r = ~|v;
      GATE_XOR:  r = ^v;
      GATE_XNOR: r = ~^v;
      default:   r = &v;
    endcase
    return r;
  endfunction

  // Applies the configured fault to a gate result when the channel is targeted.
  function automatic logic fault_apply(input logic [1:0] mode, input logic en,
                                       input logic [3:0] pattern, input logic [3:0] v,
                                       input logic g);
    logic r;
    r = g;
    if (en) begin
      case (mode)
        FAULT_SA0: r = 1'b0;
        FAULT_SA1: r = 1'b1;
        FAULT_PAT: r = (v == pattern) ? ~g : g;
        default:   r = g;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_input_ic_emulator_if.sv
// -----------------------------------------------------------------------------
// quad_input_ic_emulator_if
// Pin-level bundle between the tester and the emulated IC.
//   master : tester side (drives enable, config, gate inputs, coverage_clear)
//   slave  : emulator side (returns op/settled/coverage/cov_full)
// -----------------------------------------------------------------------------
interface quad_input_ic_emulator_if;
  logic        enable;
  logic [2:0]  gateSelect;
  logic        A1, B1, C1, D1;
  logic        A2, B2, C2, D2;
  logic [1:0]  fault_mode;
  logic [1:0]  fault_target;
  logic [3:0]  fault_pattern;
  logic        coverage_clear;
  logic        op1, op2;
  logic        settled1, settled2;
  logic [15:0] coverage1, coverage2;
  logic        cov_full;

  modport master (
    output enable, gateSelect, A1, B1, C1, D1, A2, B2, C2, D2,
           fault_mode, fault_target, fault_pattern, coverage_clear,
    input  op1, op2, settled1, settled2, coverage1, coverage2, cov_full
  );

  modport slave (
    input  enable, gateSelect, A1, B1, C1, D1, A2, B2, C2, D2,
           fault_mode, fault_target, fault_pattern, coverage_clear,
    output op1, op2, settled1, settled2, coverage1, coverage2, cov_full
  );
endinterface

// File: rtl/gate_channel_model.sv
// -----------------------------------------------------------------------------
// gate_channel_model
// One gate of the emulated IC: OFF/WAIT/SETTLED FSM with inertial delay,
// pending-vector register, fault application and 16-bit pattern coverage.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable_i        raw IC power; low forces OFF on the next edge
//   enable_q_i      power as sampled on the previous edge (gates OFF->WAIT)
//   vec_i           sampled input vector {D,C,B,A}
//   gate_sel_i, fault_mode_i, fault_pattern_i   sampled configuration
//   fault_en_i      this channel's fault_target bit
//   cfg_changed_i   configuration differs from the previous edge
//   cov_clear_i     clears the coverage map
//   op_o, settled_o, coverage_o   modelled output, settle flag, coverage map
// -----------------------------------------------------------------------------
module gate_channel_model
  import ic_tester_pkg::*;
#(
  parameter int DELAY_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             enable_q_i,
  input  logic [VEC_W-1:0] vec_i,
  input  logic [2:0]       gate_sel_i,
  input  logic [1:0]       fault_mode_i,
  input  logic [3:0]       fault_pattern_i,
  input  logic             fault_en_i,
  input  logic             cfg_changed_i,
  input  logic             cov_clear_i,
  output logic             op_o,
  output logic             settled_o,
  output logic [COV_W-1:0] coverage_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);

  ch_state_e        state_q;
  logic [VEC_W-1:0] pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_q;
  logic             settled_q;
  logic [COV_W-1:0] cov_q;
  logic [COV_W-1:0] cov_d;
  logic             restart;
  logic             settle_now;
  logic             settle_val;

  always_comb begin
    // Any pin or config movement restarts the delay (inertial behaviour).
    restart    = (vec_i != pend_q) || cfg_changed_i;
    settle_now = enable_i && (state_q == CH_WAIT) && !restart && (cnt_q == CNT_LAST);
    settle_val = fault_apply(fault_mode_i, fault_en_i, fault_pattern_i, pend_q,
                             gate_eval(gate_sel_i, pend_q));
    // A bit settling on the same edge as a clear survives the clear.
    cov_d = cov_clear_i ? '0 : cov_q;
    if (settle_now) begin
      cov_d[pend_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CH_OFF;
      pend_q    <= '0;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      settled_q <= 1'b0;
      cov_q     <= '0;
    end else begin
      // Coverage outlives power-down; only rst and coverage_clear wipe it.
      cov_q <= cov_d;
      if (!enable_i) begin
        state_q   <= CH_OFF;
        op_q      <= 1'b0;
        settled_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        case (state_q)
          CH_OFF: begin
            // Power-up is treated like a pin change: captured, then detected.
            if (enable_q_i) begin
              state_q <= CH_WAIT;
              pend_q  <= vec_i;
              cnt_q   <= '0;
            end
          end
          CH_WAIT: begin
            if (restart) begin
              pend_q <= vec_i;
              cnt_q  <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q   <= CH_SETTLED;
              op_q      <= settle_val;
              settled_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          CH_SETTLED: begin
            // op keeps its old value until the new vector settles.
            if (restart) begin
              state_q   <= CH_WAIT;
              pend_q    <= vec_i;
              cnt_q     <= '0;
              settled_q <= 1'b0;
            end
          end
          default: state_q <= CH_OFF;
        endcase
      end
    end
  end

  assign op_o       = op_q;
  assign settled_o  = settled_q;
  assign coverage_o = cov_q;

endmodule

// File: rtl/quad_input_ic_emulator.sv
// -----------------------------------------------------------------------------
// quad_input_ic_emulator
// Behavioural model of a dual 4-input gate IC for tester loopback self-test.
// Samples the gate inputs, configuration and power each edge, detects config
// changes, runs two independent gate channels and flags full coverage.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset, priority over everything
//   bus   slave side of quad_input_ic_emulator_if (pins, config, results)
// Parameter DELAY_CYCLES: propagation delay in clk cycles, legal 1..255.
// -----------------------------------------------------------------------------
module quad_input_ic_emulator
  import ic_tester_pkg::*;
#(
  parameter int DELAY_CYCLES = 4
) (
  input logic                     clk,
  input logic                     rst,
  quad_input_ic_emulator_if.slave bus
);

  logic [NUM_CH-1:0][VEC_W-1:0] vec_d;
  logic [NUM_CH-1:0][VEC_W-1:0] vec_q;
  cfg_t                         cfg_d;
  cfg_t                         cfg_q;
  cfg_t                         cfg_prev_q;
  logic                         enable_q;
  logic                         cov_full_q;
  logic                         cfg_changed;

  logic [NUM_CH-1:0]            op_w;
  logic [NUM_CH-1:0]            settled_w;
  logic [NUM_CH-1:0][COV_W-1:0] cov_w;

  assign vec_d[0] = {bus.D1, bus.C1, bus.B1, bus.A1};
  assign vec_d[1] = {bus.D2, bus.C2, bus.B2, bus.A2};
  assign cfg_d    = cfg_t'({bus.gateSelect, bus.fault_mode, bus.fault_target, bus.fault_pattern});

  // Inputs share clk with the tester, so plain registers suffice.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q      <= '0;
      cfg_q      <= '0;
      cfg_prev_q <= '0;
      enable_q   <= 1'b0;
      cov_full_q <= 1'b0;
    end else begin
      vec_q      <= vec_d;
      cfg_q      <= cfg_d;
      cfg_prev_q <= cfg_q;
      enable_q   <= bus.enable;
      cov_full_q <= (&cov_w[0]) && (&cov_w[1]);
    end
  end

  // Seen one edge after capture, matching the pin-change detection timing.
  assign cfg_changed = (cfg_q != cfg_prev_q);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    gate_channel_model #(
      .DELAY_CYCLES(DELAY_CYCLES)
    ) u_ch (
      .clk            (clk),
      .rst            (rst),
      .enable_i       (bus.enable),
      .enable_q_i     (enable_q),
      .vec_i          (vec_q[gi]),
      .gate_sel_i     (cfg_q.gate_sel),
      .fault_mode_i   (cfg_q.fault_mode),
      .fault_pattern_i(cfg_q.fault_pattern),
      .fault_en_i     (cfg_q.fault_target[gi]),
      .cfg_changed_i  (cfg_changed),
      .cov_clear_i    (bus.coverage_clear),
      .op_o           (op_w[gi]),
      .settled_o      (settled_w[gi]),
      .coverage_o     (cov_w[gi])
    );
  end

  assign bus.op1       = op_w[0];
  assign bus.op2       = op_w[1];
  assign bus.settled1  = settled_w[0];
  assign bus.settled2  = settled_w[1];
  assign bus.coverage1 = cov_w[0];
  assign bus.coverage2 = cov_w[1];
  assign bus.cov_full  = cov_full_q;

endmodule
